sobel_mag_pipe: RTL and testbench

//  Pipelined, multi-lane successor to the combinational Sobel magnitude/threshold stage.
//  Per lane: takes signed Gx/Gy and computes |Gx|+|Gy|. Saturates the result to the pixel

---
 rtl/sobel_mag_pipe.sv | 161 ++++++++++++++++
 tb/tb_sobel_mag_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_mag_pipe.sv
// Two-stage pipelined Sobel magnitude/threshold stage with valid/ready flow control and a per-frame edge counter.
// Optional build macro EDGE_BINARY_EN: when defined, out_pix carries a binary edge map instead of the magnitude.
module sobel_mag_pipe #(
    parameter int unsigned GRAD_W = 11,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned LANES  = 4,
    parameter int unsigned CNT_W  = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*GRAD_W-1:0]   in_gx,
    input  logic [LANES*GRAD_W-1:0]   in_gy,
    input  logic                      in_last,
    input  logic [PIX_W-1:0]          thresh,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*PIX_W-1:0]    out_pix,
    output logic [LANES-1:0]          out_edge,
    output logic                      out_last,
    output logic [CNT_W-1:0]          frame_edges,
    output logic                      frame_done
);

    localparam int unsigned SUM_W = GRAD_W + 1;
    localparam int unsigned PC_W  = $clog2(LANES + 1);
    localparam int unsigned ACC_W = CNT_W + PC_W;
    localparam logic [PIX_W-1:0] PIX_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                    rdy_en;
    logic                    s1_valid;
    logic [LANES*GRAD_W-1:0] s1_ax;
    logic [LANES*GRAD_W-1:0] s1_ay;
    logic [PIX_W-1:0]        s1_thresh;
    logic                    s1_last;

    logic                    s1_load;
    logic                    s2_load;
    logic                    in_fire;
    logic                    out_fire;

    logic [LANES*GRAD_W-1:0] abs_x;
    logic [LANES*GRAD_W-1:0] abs_y;
    logic [SUM_W-1:0]        lane_sum;
    logic [PIX_W-1:0]        lane_sat;
    logic [LANES*PIX_W-1:0]  pix_nxt;
    logic [LANES-1:0]        hit_nxt;

    logic [CNT_W-1:0]        running;
    logic [PC_W-1:0]         hit_cnt;
    logic [ACC_W-1:0]        acc_sum;
    logic [CNT_W-1:0]        acc_sat;

    // Magnitude of a two's-complement value; the most negative input maps to 2**(GRAD_W-1).
    function automatic logic [GRAD_W-1:0] abs_g(input logic [GRAD_W-1:0] v);
        return v[GRAD_W-1] ? GRAD_W'((~v) + GRAD_W'(1)) : v;
    endfunction

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = rdy_en && s1_load;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        abs_x = '0;
        abs_y = '0;
        for (int i = 0; i < LANES; i++) begin
            abs_x[i*GRAD_W +: GRAD_W] = abs_g(in_gx[i*GRAD_W +: GRAD_W]);
            abs_y[i*GRAD_W +: GRAD_W] = abs_g(in_gy[i*GRAD_W +: GRAD_W]);
        end
    end

    // Stage 1: absolute values plus threshold and frame marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en    <= 1'b0;
            s1_valid  <= 1'b0;
            s1_ax     <= '0;
            s1_ay     <= '0;
            s1_thresh <= '0;
            s1_last   <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (s1_load) begin
                s1_valid <= in_fire;
                if (in_fire) begin
                    s1_ax     <= abs_x;
                    s1_ay     <= abs_y;
                    s1_thresh <= thresh;
                    s1_last   <= in_last;
                end
            end
        end
    end

    always_comb begin
        lane_sum = '0;
        lane_sat = '0;
        pix_nxt  = '0;
        hit_nxt  = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum   = {1'b0, s1_ax[i*GRAD_W +: GRAD_W]} + {1'b0, s1_ay[i*GRAD_W +: GRAD_W]};
            lane_sat   = (lane_sum > SUM_W'(PIX_MAX)) ? PIX_MAX : lane_sum[PIX_W-1:0];
            hit_nxt[i] = lane_sat > s1_thresh;
`ifdef EDGE_BINARY_EN
            pix_nxt[i*PIX_W +: PIX_W] = hit_nxt[i] ? PIX_MAX : '0;
`else
            pix_nxt[i*PIX_W +: PIX_W] = lane_sat;
`endif
        end
    end

    // Stage 2: saturated sum and threshold compare; holds while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_edge  <= '0;
            out_last  <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_pix  <= pix_nxt;
                out_edge <= hit_nxt;
                out_last <= s1_last;
            end
        end
    end

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            hit_cnt = hit_cnt + PC_W'(out_edge[i]);
        end
        acc_sum = ACC_W'(running) + ACC_W'(hit_cnt);
        acc_sat = (acc_sum > ACC_W'(CNT_MAX)) ? CNT_MAX : acc_sum[CNT_W-1:0];
    end

    // Per-frame edge accumulation, published on the last output beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running     <= '0;
            frame_edges <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= out_fire && out_last;
            if (out_fire) begin
                if (out_last) begin
                    frame_edges <= acc_sat;
                    running     <= '0;
                end else begin
                    running <= acc_sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_mag_pipe.sv
// Self-checking bench for sobel_mag_pipe: directed cases plus randomized beats against an arithmetic model.
module tb_sobel_mag_pipe;

    localparam int GRAD_W = 11;
    localparam int PIX_W  = 8;
    localparam int LANES  = 4;
    localparam int CNT_W  = 20;
    localparam int PMAX   = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                    in_valid = 1'b0;
    logic [LANES*GRAD_W-1:0] in_gx = '0;
    logic [LANES*GRAD_W-1:0] in_gy = '0;
    logic                    in_last = 1'b0;
    logic [PIX_W-1:0]        thresh = '0;
    logic                    out_ready = 1'b0;

    wire                     in_ready;
    wire                     out_valid;
    wire [LANES*PIX_W-1:0]   out_pix;
    wire [LANES-1:0]         out_edge;
    wire                     out_last;
    wire [CNT_W-1:0]         frame_edges;
    wire                     frame_done;

    wire                     in_ready3;
    wire                     out_valid3;
    wire [LANES*PIX_W-1:0]   out_pix3;
    wire [LANES-1:0]         out_edge3;
    wire                     out_last3;
    wire [2:0]               frame_edges3;
    wire                     frame_done3;

    sobel_mag_pipe #(.GRAD_W(GRAD_W), .PIX_W(PIX_W), .LANES(LANES), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_gx(in_gx), .in_gy(in_gy), .in_last(in_last), .thresh(thresh),
        .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
        .out_edge(out_edge), .out_last(out_last),
        .frame_edges(frame_edges), .frame_done(frame_done)
    );

    // Narrow-counter instance sharing the same stimulus, to exercise counter saturation.
    sobel_mag_pipe #(.GRAD_W(GRAD_W), .PIX_W(PIX_W), .LANES(LANES), .CNT_W(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
        .in_gx(in_gx), .in_gy(in_gy), .in_last(in_last), .thresh(thresh),
        .out_valid(out_valid3), .out_ready(out_ready), .out_pix(out_pix3),
        .out_edge(out_edge3), .out_last(out_last3),
        .frame_edges(frame_edges3), .frame_done(frame_done3)
    );

    typedef struct packed {
        logic [LANES*PIX_W-1:0] pix;
        logic [LANES-1:0]       hit;
        logic                   last;
    } beat_t;

    beat_t q[$];
    beat_t cur;
    int    checks = 0;
    int    errors = 0;
    int    run = 0, run3 = 0, exp_fe = 0, exp_fe3 = 0;
    bit    pend = 1'b0;
    bit    ready_chk = 1'b0;
    int    or_mode = 0;
    int    pidx = 0;
    int    bgx[LANES];
    int    bgy[LANES];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: |gx|+|gy| clamped to the pixel range, compared with the threshold.
    function automatic beat_t model(input logic [LANES*GRAD_W-1:0] gx, input logic [LANES*GRAD_W-1:0] gy,
                                    input logic [PIX_W-1:0] th, input logic last);
        beat_t b;
        int a, c, mag;
        b = '0;
        for (int i = 0; i < LANES; i++) begin
            a   = int'($signed(gx[i*GRAD_W +: GRAD_W]));
            c   = int'($signed(gy[i*GRAD_W +: GRAD_W]));
            mag = (a < 0 ? -a : a) + (c < 0 ? -c : c);
            if (mag > PMAX) mag = PMAX;
            b.hit[i] = mag > int'(th);
`ifdef EDGE_BINARY_EN
            b.pix[i*PIX_W +: PIX_W] = b.hit[i] ? 8'd255 : 8'd0;
`else
            b.pix[i*PIX_W +: PIX_W] = 8'(mag);
`endif
        end
        b.last = last;
        return b;
    endfunction

    always @(posedge clk) begin
        #1;
        case (or_mode)
            0: out_ready = 1'b1;
            1: begin out_ready = (pidx % 3 == 0); pidx++; end
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Scoreboard and frame-counter model, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (ready_chk) chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
            chk("frame_done", frame_done, pend);
            chk("frame_done3", frame_done3, pend);
            chk("frame_edges", frame_edges, exp_fe);
            chk("frame_edges3", frame_edges3, exp_fe3);
            pend = 1'b0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    cur = q.pop_front();
                    chk("out_pix", out_pix, cur.pix);
                    chk("out_edge", out_edge, cur.hit);
                    chk("out_last", out_last, cur.last);
                    run  = run + $countones(cur.hit);
                    if (run > (2**CNT_W) - 1) run = (2**CNT_W) - 1;
                    run3 = run3 + $countones(cur.hit);
                    if (run3 > 7) run3 = 7;
                    if (cur.last) begin
                        exp_fe  = run;
                        exp_fe3 = run3;
                        run  = 0;
                        run3 = 0;
                        pend = 1'b1;
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(model(in_gx, in_gy, thresh, in_last));
        end
    end

    task automatic send(input logic [PIX_W-1:0] th, input logic last);
        bit acc;
        int n;
        for (int i = 0; i < LANES; i++) begin
            in_gx[i*GRAD_W +: GRAD_W] = GRAD_W'(bgx[i]);
            in_gy[i*GRAD_W +: GRAD_W] = GRAD_W'(bgy[i]);
        end
        thresh   = th;
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic set_lanes(input int gx, input int gy, input logic [LANES-1:0] sel);
        for (int i = 0; i < LANES; i++) begin
            bgx[i] = sel[i] ? gx : 1;
            bgy[i] = sel[i] ? gy : 1;
        end
    endtask

    task automatic rand_beat();
        for (int i = 0; i < LANES; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                bgx[i] = int'($urandom_range(0, 2047)) - 1024;
                bgy[i] = int'($urandom_range(0, 2047)) - 1024;
            end else begin
                bgx[i] = int'($urandom_range(0, 300)) - 150;
                bgy[i] = int'($urandom_range(0, 300)) - 150;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 30);
        if (!frame_done) chk("frame_done_timeout", 0, 1);
    endtask

    initial begin
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pix", out_pix, 0);
        chk("rst_out_edge", out_edge, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_frame_edges", frame_edges, 0);
        chk("rst_frame_done", frame_done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        ready_chk = 1'b1;
        chk("in_ready_after_reset", in_ready, 1);
        idle(2);

        // Single-lane magnitude and latency.
        set_lanes(0, 0, '0);
        for (int i = 0; i < LANES; i++) begin bgx[i] = 0; bgy[i] = 0; end
        bgx[0] = -3;
        bgy[0] = 5;
        send(8'd7, 1'b1);
        chk("lat_not_early", out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_valid", out_valid, 1);
`ifdef EDGE_BINARY_EN
        chk("t1_pix0", out_pix[7:0], 8'd255);
`else
        chk("t1_pix0", out_pix[7:0], 8'd8);
`endif
        chk("t1_edge0", out_edge[0], 1);
        idle(3);

        // Saturation boundaries.
        bgx[0] = -1024; bgy[0] = -1024;
        bgx[1] = 200;   bgy[1] = 55;
        bgx[2] = 200;   bgy[2] = 54;
        bgx[3] = 0;     bgy[3] = 0;
        send(8'd254, 1'b1);
        @(posedge clk);
        #1;
`ifdef EDGE_BINARY_EN
        chk("t2_pix", out_pix, 32'h0000FFFF);
`else
        chk("t2_pix", out_pix, 32'h00FEFFFF);
`endif
        chk("t2_edge", out_edge, 4'b0011);
        idle(3);

        // Ten beats under a 1,0,0 backpressure pattern.
        pidx = 0;
        or_mode = 1;
        for (int k = 0; k < 10; k++) begin
            rand_beat();
            send(8'($urandom_range(0, 255)), k == 9);
        end
        or_mode = 0;
        idle(6);

        // Frame of 2 + 4 + 1 edge lanes, then a single-beat frame.
        set_lanes(20, 0, 4'b0011); send(8'd10, 1'b0);
        set_lanes(20, 0, 4'b1111); send(8'd10, 1'b0);
        set_lanes(20, 0, 4'b0001); send(8'd10, 1'b1);
        wait_done();
        chk("t4_frame_edges", frame_edges, 7);
        chk("t4_frame_edges3", frame_edges3, 7);
        @(posedge clk);
        #1;
        set_lanes(-20, 0, 4'b0100); send(8'd10, 1'b1);
        wait_done();
        chk("t4_restart", frame_edges, 1);
        @(posedge clk);
        #1;

        // Twelve edges per frame: the 3-bit counter must clamp.
        set_lanes(100, -100, 4'b1111); send(8'd0, 1'b0);
        send(8'd0, 1'b0);
        send(8'd0, 1'b1);
        wait_done();
        chk("t6_frame_edges", frame_edges, 12);
        chk("t6_sat3", frame_edges3, 7);
        @(posedge clk);
        #1;

        // Random traffic under random backpressure.
        or_mode = 2;
        for (int k = 0; k < 300; k++) begin
            rand_beat();
            send(8'($urandom_range(0, 255)), (k == 299) || ($urandom_range(0, 7) == 0));
        end
        or_mode = 0;
        idle(8);

        // Reset with two beats in flight.
        or_mode = 3;
        idle(1);
        set_lanes(300, 300, 4'b1111); send(8'd0, 1'b1);
        send(8'd0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        ready_chk = 1'b0;
        q.delete();
        run = 0; run3 = 0; exp_fe = 0; exp_fe3 = 0; pend = 1'b0;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_out_pix", out_pix, 0);
        chk("t5_out_edge", out_edge, 0);
        chk("t5_out_last", out_last, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        or_mode = 0;
        @(posedge clk);
        #1;
        ready_chk = 1'b1;
        chk("t5_in_ready", in_ready, 1);
        idle(10);
        chk("t5_no_stale", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
